program_loader: RTL and testbench

Byte-serial loader that writes the processor's 256-entry program page. A host streams framed bytes in over a valid/ready handshake. The block assembles 16-bit instruction sets, writes them to consecutive page lines, and checks a frame checksum. While a frame is in progress it holds the processor off with `busy`, and on completion it reports the frame's start line so execution can begin there.

---
 rtl/program_loader.sv | 212 +++++++++++++++++++++
 tb/tb_program_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-serial program page loader: parses SYNC/ADDR/COUNT/data/CS frames, writes
// 16-bit instruction sets to consecutive page lines and verifies an XOR checksum.
module program_loader #(
    parameter logic [7:0] SYNC_BYTE              = 8'hA5,
    parameter int         INSTRUCTION_SET_LENGTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              wr_en,
    output logic [7:0]                        wr_addr,
    output logic [INSTRUCTION_SET_LENGTH-1:0] wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [7:0]                        start_addr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_COUNT  = 3'd2,
        ST_HI     = 3'd3,
        ST_LO     = 3'd4,
        ST_CS     = 3'd5,
        ST_REPORT = 3'd6
    } state_t;

    function automatic logic [7:0] cs_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                              state_q, state_d;
    logic [7:0]                          ptr_q, ptr_d;
    logic [7:0]                          frame_q, frame_d;
    logic [8:0]                          rem_q, rem_d;
    logic [7:0]                          cs_q, cs_d;
    logic [7:0]                          hi_q, hi_d;
    logic                                in_ready_q, in_ready_d;
    logic                                wr_en_q, wr_en_d;
    logic [7:0]                          wr_addr_q, wr_addr_d;
    logic [INSTRUCTION_SET_LENGTH-1:0]   wr_data_q, wr_data_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                err_q, err_d;
    logic [7:0]                          start_addr_q, start_addr_d;
    logic                                accept_s;

    assign accept_s = in_valid && in_ready_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the frame advances only on accepted bytes, gaps hold state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (in_data == SYNC_BYTE)) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (accept_s) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_COUNT: begin
                if (accept_s) begin
                    state_d = ST_HI;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_HI: begin
                if (accept_s) begin
                    state_d = ST_LO;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_LO: begin
                if (accept_s && (rem_q == 9'd1)) begin
                    state_d = ST_CS;
                end else if (accept_s) begin
                    state_d = ST_HI;
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_CS: begin
                if (accept_s) begin
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_CS;
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic; handshake and status flags follow the next state.
    always_comb begin
        ptr_d        = ptr_q;
        frame_d      = frame_q;
        rem_d        = rem_q;
        cs_d         = cs_q;
        hi_d         = hi_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        start_addr_d = start_addr_q;
        in_ready_d   = (state_d != ST_REPORT);
        busy_d       = (state_d != ST_IDLE);
        if (accept_s) begin
            case (state_q)
                ST_ADDR: begin
                    ptr_d   = in_data;
                    frame_d = in_data;
                    cs_d    = in_data;
                end
                ST_COUNT: begin
                    rem_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    cs_d  = cs_fold(cs_q, in_data);
                end
                ST_HI: begin
                    hi_d = in_data;
                    cs_d = cs_fold(cs_q, in_data);
                end
                ST_LO: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = {hi_q, in_data};
                    ptr_d     = ptr_q + 8'd1;
                    rem_d     = rem_q - 9'd1;
                    cs_d      = cs_fold(cs_q, in_data);
                end
                ST_CS: begin
                    if (in_data == cs_q) begin
                        done_d       = 1'b1;
                        start_addr_d = frame_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    ptr_d = ptr_q;
                end
            endcase
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 8'd0;
            frame_q      <= 8'd0;
            rem_q        <= 9'd0;
            cs_q         <= 8'd0;
            hi_q         <= 8'd0;
            in_ready_q   <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            start_addr_q <= 8'd0;
        end else begin
            ptr_q        <= ptr_d;
            frame_q      <= frame_d;
            rem_q        <= rem_d;
            cs_q         <= cs_d;
            hi_q         <= hi_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            start_addr_q <= start_addr_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign start_addr = start_addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: framed streams with hand-computed writes.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  start_addr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] wq[$];
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;

    program_loader #(.SYNC_BYTE(8'hA5), .INSTRUCTION_SET_LENGTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .start_addr (start_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (done) n_done <= n_done + 1;
        if (err) n_err <= n_err + 1;
        if (done && err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gaps);
        foreach (f[i]) begin
            if (gaps) idle($urandom_range(0, 3));
            send_byte(f[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] fr[$];
        int wb, db, eb, bad;
        logic [7:0] b;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_start_addr", 32'(start_addr), 32'd0);

        // Good frame, back-to-back, with timing probes.
        wb = wq.size(); db = n_done; eb = n_err;
        send_byte(8'hA5);
        check("busy_after_sync", 32'(busy), 32'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h40); send_byte(8'h1C);
        check("wr_en_after_lo", 32'(wr_en), 32'd1);
        check("wr_addr_first", 32'(wr_addr), 32'h01);
        check("wr_data_first", 32'(wr_data), 32'h401C);
        send_byte(8'h88);
        check("wr_en_after_hi", 32'(wr_en), 32'd0);
        check("wr_data_hold", 32'(wr_data), 32'h401C);
        send_byte(8'h0A); send_byte(8'hDD);
        check("report_done", 32'(done), 32'd1);
        check("report_err", 32'(err), 32'd0);
        check("report_in_ready", 32'(in_ready), 32'd0);
        check("report_busy", 32'(busy), 32'd1);
        check("report_start_addr", 32'(start_addr), 32'h01);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_done", 32'(done), 32'd0);
        idle(3);
        check("good_nwrites", 32'(wq.size() - wb), 32'd2);
        check("good_w0", 32'(wq[wb]), 32'h01401C);
        check("good_w1", 32'(wq[wb+1]), 32'h02880A);
        check("good_ndone", 32'(n_done - db), 32'd1);
        check("good_nerr", 32'(n_err - eb), 32'd0);

        // Pointer wrap FF -> 00; CS = FF^02^11^22^33^44 = B9.
        wb = wq.size(); db = n_done; eb = n_err;
        fr = '{8'hA5, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB9};
        send_frame(fr, 1'b0);
        idle(3);
        check("wrap_nwrites", 32'(wq.size() - wb), 32'd2);
        check("wrap_w0", 32'(wq[wb]), 32'hFF1122);
        check("wrap_w1", 32'(wq[wb+1]), 32'h003344);
        check("wrap_ndone", 32'(n_done - db), 32'd1);
        check("wrap_start_addr", 32'(start_addr), 32'hFF);

        // Bad checksum: writes still land, start_addr keeps FF.
        wb = wq.size(); db = n_done; eb = n_err;
        fr = '{8'hA5, 8'h01, 8'h02, 8'h40, 8'h1C, 8'h88, 8'h0A, 8'h00};
        send_frame(fr, 1'b0);
        idle(3);
        check("bad_nwrites", 32'(wq.size() - wb), 32'd2);
        check("bad_w0", 32'(wq[wb]), 32'h01401C);
        check("bad_w1", 32'(wq[wb+1]), 32'h02880A);
        check("bad_ndone", 32'(n_done - db), 32'd0);
        check("bad_nerr", 32'(n_err - eb), 32'd1);
        check("bad_start_addr", 32'(start_addr), 32'hFF);

        // Garbage then gapped frame with A5 as data; CS = 01^02^A5^1C^88^0A = 38.
        wb = wq.size(); db = n_done; eb = n_err;
        fr = '{8'h00, 8'hFF, 8'h3C};
        send_frame(fr, 1'b1);
        check("garbage_busy", 32'(busy), 32'd0);
        fr = '{8'hA5, 8'h01, 8'h02, 8'hA5, 8'h1C, 8'h88, 8'h0A, 8'h38};
        send_frame(fr, 1'b1);
        idle(3);
        check("gap_nwrites", 32'(wq.size() - wb), 32'd2);
        check("gap_w0", 32'(wq[wb]), 32'h01A51C);
        check("gap_w1", 32'(wq[wb+1]), 32'h02880A);
        check("gap_ndone", 32'(n_done - db), 32'd1);
        check("gap_nerr", 32'(n_err - eb), 32'd0);
        check("gap_start_addr", 32'(start_addr), 32'h01);

        // Reset after the first data pair of a 2-entry frame.
        wb = wq.size(); db = n_done; eb = n_err;
        fr = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22};
        send_frame(fr, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check("mid_rst_start_addr", 32'(start_addr), 32'd0);
        idle(3);
        check("mid_rst_nwrites", 32'(wq.size() - wb), 32'd1);
        check("mid_rst_w0", 32'(wq[wb]), 32'h101122);
        check("mid_rst_ndone", 32'(n_done - db), 32'd0);
        check("mid_rst_nerr", 32'(n_err - eb), 32'd0);

        wb = wq.size(); db = n_done; eb = n_err;
        fr = '{8'hA5, 8'h01, 8'h02, 8'h40, 8'h1C, 8'h88, 8'h0A, 8'hDD};
        send_frame(fr, 1'b0);
        idle(3);
        check("after_rst_nwrites", 32'(wq.size() - wb), 32'd2);
        check("after_rst_w1", 32'(wq[wb+1]), 32'h02880A);
        check("after_rst_ndone", 32'(n_done - db), 32'd1);
        check("after_rst_start_addr", 32'(start_addr), 32'h01);

        // Full page: COUNT=00, pair i = {i, ~i}; each pair XORs to FF, 256 of them cancel, so CS = 00.
        wb = wq.size(); db = n_done; eb = n_err;
        fr = '{8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            fr.push_back(b);
            fr.push_back(~b);
        end
        fr.push_back(8'h00);
        send_frame(fr, 1'b0);
        idle(3);
        check("full_nwrites", 32'(wq.size() - wb), 32'd256);
        bad = 0;
        if (wq.size() - wb == 256) begin
            for (int i = 0; i < 256; i++) begin
                b = i[7:0];
                if (wq[wb+i] !== {b, b, ~b}) bad++;
            end
        end else begin
            bad = -1;
        end
        check("full_order_errors", 32'(bad), 32'd0);
        check("full_ndone", 32'(n_done - db), 32'd1);
        check("full_nerr", 32'(n_err - eb), 32'd0);
        check("full_start_addr", 32'(start_addr), 32'h00);

        check("done_err_exclusive", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
